// File: rtl/trig_rom_arbiter_if.sv
// Requester/ROM bundle for trig_rom_arbiter: angle requests in, sin/cos results out, one ROM port.
// slave = arbiter side; master = requesters plus ROM data source.
interface trig_rom_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0][8:0]   req_angle;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0][31:0]  rsp_sin;
   logic [NUM_REQ-1:0][31:0]  rsp_cos;
   logic [8:0]                rom_angle;
   logic [31:0]               rom_sin_value;
   logic                      busy;

   modport slave (
      input  req_valid, req_angle, rom_sin_value,
      output req_ready, rsp_valid, rsp_sin, rsp_cos, rom_angle, busy
   );

   modport master (
      output req_valid, req_angle, rom_sin_value,
      input  req_ready, rsp_valid, rsp_sin, rsp_cos, rom_angle, busy
   );
endinterface

// File: rtl/trig_rom_arbiter.sv
// Round-robin sharing of one sine ROM; each grant yields sin and cos (cos = ROM[(a+90) mod 360]).
// Accept->rsp_valid in 3+2*ROM_LAT cycles; req_ready only in IDLE, so requesters wait while busy.
module trig_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ROM_LAT = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   trig_rom_arbiter_if.slave  bus
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SIN, COS, RESP} state_e;

   state_e                    state_q, state_d;
   logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]             gnt_q, gnt_d;
   logic [8:0]                ang_q, ang_d;
   logic [WW-1:0]             wait_q, wait_d;
   logic [31:0]               sin_tmp_q, sin_tmp_d;
   logic [NUM_REQ-1:0][31:0]  rsp_sin_q, rsp_sin_d;
   logic [NUM_REQ-1:0][31:0]  rsp_cos_q, rsp_cos_d;

   logic                      found;
   logic [PW-1:0]             pick;
   int                        idx;
   logic [9:0]                a10;
   logic [9:0]                an10;
   logic [9:0]                cos10;
   logic                      last;
   logic [NUM_REQ-1:0]        req_ready_c;
   logic [NUM_REQ-1:0]        rsp_valid_c;
   logic [8:0]                rom_angle_c;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   // Inputs up to 511 need only a single subtraction to land in 0..359.
   always_comb begin
      a10   = {1'b0, bus.req_angle[pick]};
      an10  = (a10 >= 10'd360) ? a10 - 10'd360 : a10;
      cos10 = ({1'b0, ang_q} + 10'd90 >= 10'd360) ? {1'b0, ang_q} - 10'd270
                                                  : {1'b0, ang_q} + 10'd90;
   end

   assign last = (wait_q == WW'(ROM_LAT));

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      ang_d       = ang_q;
      wait_d      = wait_q;
      sin_tmp_d   = sin_tmp_q;
      rsp_sin_d   = rsp_sin_q;
      rsp_cos_d   = rsp_cos_q;
      req_ready_c = '0;
      rsp_valid_c = '0;
      rom_angle_c = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               req_ready_c[pick] = 1'b1;
               gnt_d             = pick;
               ang_d             = an10[8:0];
               wait_d            = '0;
               state_d           = SIN;
            end
         end
         SIN: begin
            rom_angle_c = ang_q;
            if (last) begin
               sin_tmp_d = bus.rom_sin_value;
               wait_d    = '0;
               state_d   = COS;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         COS: begin
            rom_angle_c = cos10[8:0];
            // Results land in the per-requester registers as RESP begins, so they are valid alongside rsp_valid.
            if (last) begin
               rsp_sin_d[gnt_q] = sin_tmp_q;
               rsp_cos_d[gnt_q] = bus.rom_sin_value;
               wait_d           = '0;
               state_d          = RESP;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         RESP: begin
            rsp_valid_c[gnt_q] = 1'b1;
            rr_ptr_d = (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         gnt_q     <= '0;
         ang_q     <= '0;
         wait_q    <= '0;
         sin_tmp_q <= '0;
         rsp_sin_q <= '0;
         rsp_cos_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_q     <= gnt_d;
         ang_q     <= ang_d;
         wait_q    <= wait_d;
         sin_tmp_q <= sin_tmp_d;
         rsp_sin_q <= rsp_sin_d;
         rsp_cos_q <= rsp_cos_d;
      end
   end

   // The accept strobe is combinational off req_valid, so it is masked while reset is held.
   assign bus.req_ready = reset_n ? req_ready_c : '0;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_sin   = rsp_sin_q;
   assign bus.rsp_cos   = rsp_cos_q;
   assign bus.rom_angle = rom_angle_c;
   assign bus.busy      = (state_q != IDLE);

endmodule
